uart_transmitter: RTL and testbench

UART_TRANSMITTER -- requirements
Module: uart_transmitter

---
 rtl/uart_transmitter.sv | 184 ++++++++++++++++++
 tb/tb_uart_transmitter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// uart_transmitter
//   Byte-oriented UART transmitter. A 4-entry FIFO sits in front of the
//   serial state machine. Frames are start bit, 8 data bits LSB first,
//   an optional even-parity bit, and a stop bit. There is no bypass path:
//   every byte goes through the FIFO. A byte pushed into an empty FIFO
//   while idle starts its start bit one clock after acceptance.
//   Queued bytes go out back-to-back with no idle gap between frames.
//
//   Build option: define UART_TX_PARITY_EN to insert the even-parity bit.
//   The frame is then 11 bits; otherwise it is 10 bits.
//
//   Parameters
//     BAUD_TICK_COUNT  clocks per bit minus one
//     FIFO_DEPTH       transmit FIFO entries (only 4 is supported)
//
//   Ports
//     clk         system clock, rising edge
//     rst         asynchronous active-high reset
//     tx_data     byte to send
//     tx_valid    tx_data offered this cycle
//     tx_ready    FIFO can accept a byte this cycle
//     uart_tx     serial line, idles high, driven from a flop
//     tx_busy     frame in progress or FIFO non-empty
//     tx_done     one-cycle pulse on the last clock of each stop bit
//     fifo_count  bytes currently held in the FIFO (0..4)
module uart_transmitter #(
  parameter logic [31:0] BAUD_TICK_COUNT = 32'd10416,
  parameter int          FIFO_DEPTH      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       uart_tx,
  output logic       tx_busy,
  output logic       tx_done,
  output logic [2:0] fifo_count
);

  localparam logic [2:0] FULL_COUNT = 3'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t      state;
  logic [7:0]  mem [FIFO_DEPTH];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [7:0]  head_byte;
  logic [7:0]  shift_reg;
  logic [2:0]  bit_idx;
  logic [31:0] baud_cnt;
  logic        push;
  logic        pop;
  logic        bit_end;
`ifdef UART_TX_PARITY_EN
  logic        parity_bit;
`endif

  // A full FIFO refuses the push even when a pop happens in the same cycle.
  assign tx_ready  = (fifo_count != FULL_COUNT);
  assign push      = tx_valid && tx_ready;
  assign bit_end   = (baud_cnt == 32'd0);
  // The FSM pops when idle, or at the end of a stop bit to chain frames.
  assign pop       = (fifo_count != 3'd0) &&
                     ((state == IDLE) || ((state == STOP) && bit_end));
  assign tx_busy   = (state != IDLE) || (fifo_count != 3'd0);
  assign head_byte = mem[rd_ptr];

  // FIFO control: 2-bit pointers wrap naturally from 3 to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      fifo_count <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FIFO storage carries data only and needs no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  // Serial FSM; all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      uart_tx   <= 1'b1;
      tx_done   <= 1'b0;
      baud_cnt  <= 32'd0;
      bit_idx   <= 3'd0;
      shift_reg <= 8'd0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      if (state != IDLE) begin
        baud_cnt <= bit_end ? BAUD_TICK_COUNT : baud_cnt - 32'd1;
      end
      case (state)
        IDLE: begin
          uart_tx <= 1'b1;
          if (pop) begin
            shift_reg <= head_byte;
            baud_cnt  <= BAUD_TICK_COUNT;
            uart_tx   <= 1'b0;
            state     <= START;
          end
        end
        START: begin
          if (bit_end) begin
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^shift_reg;
`endif
            uart_tx   <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            bit_idx   <= 3'd0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              uart_tx <= parity_bit;
              state   <= PARITY;
`else
              uart_tx <= 1'b1;
              tx_done <= (BAUD_TICK_COUNT == 32'd0);
              state   <= STOP;
`endif
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              uart_tx   <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            uart_tx <= 1'b1;
            tx_done <= (BAUD_TICK_COUNT == 32'd0);
            state   <= STOP;
          end
        end
`endif
        STOP: begin
          // Raise tx_done one edge early so it covers the final stop clock.
          if (baud_cnt == 32'd1) tx_done <= 1'b1;
          if (bit_end) begin
            if (pop) begin
              shift_reg <= head_byte;
              uart_tx   <= 1'b0;
              state     <= START;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          uart_tx <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
module tb_uart_transmitter;

  localparam logic [31:0] BAUD   = 32'd3;
  localparam int          BITCLK = 4;
`ifdef UART_TX_PARITY_EN
  localparam int          FBITS  = 11;
`else
  localparam int          FBITS  = 10;
`endif
  localparam int          FCLK   = FBITS * BITCLK;
  localparam int          MAXREC = 2000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'd0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       uart_tx;
  logic       tx_busy;
  logic       tx_done;
  logic [2:0] fifo_count;

  uart_transmitter #(.BAUD_TICK_COUNT(BAUD), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .uart_tx(uart_tx), .tx_busy(tx_busy),
    .tx_done(tx_done), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int now      = 0;

  // Per-clock recording of outputs, sampled on the falling edge.
  logic       cap_tx   [MAXREC];
  logic       cap_done [MAXREC];
  logic       cap_busy [MAXREC];
  logic [2:0] cap_cnt  [MAXREC];
  int         rec_n  = 0;
  bit         rec_on = 1'b0;

  always @(negedge clk) begin
    if (rec_on && rec_n < MAXREC) begin
      cap_tx[rec_n]   = uart_tx;
      cap_done[rec_n] = tx_done;
      cap_busy[rec_n] = tx_busy;
      cap_cnt[rec_n]  = fifo_count;
      rec_n++;
    end
  end

  // Reference model: list of accepted bytes and the sample index of the
  // edge that accepted each one. Sample t is taken just after edge t.
  int         m_acc  [$];
  logic [7:0] m_byte [$];

  function automatic logic frame_bit(logic [7:0] b, int i);
    logic [7:0] sh;
    if (i == 0) return 1'b0;
    if (i <= 8) begin
      sh = b >> (i - 1);
      return sh[0];
    end
`ifdef UART_TX_PARITY_EN
    if (i == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // A frame starts one clock after acceptance, or right when the previous
  // frame ends, whichever is later.
  function automatic int m_start(int k);
    int s = 0;
    for (int i = 0; i <= k; i++) begin
      if (i == 0) s = m_acc[0] + 1;
      else s = (m_acc[i] + 1 > s + FCLK) ? m_acc[i] + 1 : s + FCLK;
    end
    return s;
  endfunction

  function automatic logic exp_line(int t);
    int st;
    for (int k = 0; k < m_acc.size(); k++) begin
      st = m_start(k);
      if (t >= st && t < st + FCLK) return frame_bit(m_byte[k], (t - st) / BITCLK);
    end
    return 1'b1;
  endfunction

  function automatic logic exp_done(int t);
    for (int k = 0; k < m_acc.size(); k++)
      if (t == m_start(k) + FCLK - 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic exp_busy(int t);
    for (int k = 0; k < m_acc.size(); k++)
      if (t >= m_acc[k] && t < m_start(k) + FCLK) return 1'b1;
    return 1'b0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    tx_valid = 1'b0;
    rec_on = 1'b0;
    m_acc.delete();
    m_byte.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Offer the first byte; recording starts right after its accepting edge.
  task automatic first_push(input logic [7:0] b);
    @(negedge clk);
    tx_data = b;
    tx_valid = 1'b1;
    m_acc.push_back(0);
    m_byte.push_back(b);
    @(posedge clk);
    #1;
    rec_n = 0;
    rec_on = 1'b1;
    now = -1;
  endtask

  task automatic tick();
    @(negedge clk);
    now++;
  endtask

  task automatic test_reset();
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL reset_uart_tx got=%b exp=1", uart_tx); end
    n_checks++; if (tx_done !== 1'b0) begin n_fail++; $display("FAIL reset_tx_done got=%b exp=0", tx_done); end
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_tx_busy got=%b exp=0", tx_busy); end
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_fifo_count got=%0d exp=0", fifo_count); end
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rec_n = 0;
    rec_on = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    rec_on = 1'b0;
    for (int t = 0; t < rec_n; t++) begin
      n_checks++;
      if (cap_tx[t] !== 1'b1 || cap_busy[t] !== 1'b0 || cap_done[t] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle t=%0d got tx/busy/done=%b%b%b exp=100", t, cap_tx[t], cap_busy[t], cap_done[t]);
      end
    end
  endtask

  task automatic test_single_frames();
    logic [7:0] list [5];
    list[0] = 8'hA5;
    list[1] = 8'h07;
    for (int i = 2; i < 5; i++) list[i] = 8'($urandom);
    for (int i = 0; i < 5; i++) begin
      do_reset();
      first_push(list[i]);
      tick();
      tx_valid = 1'b0;
      repeat (FCLK + 3) tick();
      #1;
      rec_on = 1'b0;
      for (int t = 0; t < rec_n; t++) begin
        n_checks++;
        if (cap_tx[t] !== exp_line(t)) begin
          n_fail++;
          $display("FAIL single_line byte=%h t=%0d got=%b exp=%b", list[i], t, cap_tx[t], exp_line(t));
        end
        n_checks++;
        if (cap_done[t] !== exp_done(t)) begin
          n_fail++;
          $display("FAIL single_done byte=%h t=%0d got=%b exp=%b", list[i], t, cap_done[t], exp_done(t));
        end
        n_checks++;
        if (cap_busy[t] !== exp_busy(t)) begin
          n_fail++;
          $display("FAIL single_busy byte=%h t=%0d got=%b exp=%b", list[i], t, cap_busy[t], exp_busy(t));
        end
      end
    end
  endtask

  task automatic test_fifo_full();
    do_reset();
    first_push(8'h01);
    for (int j = 1; j < 5; j++) begin
      tick();
      n_checks++;
      if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_push%0d got=%b exp=1", j, tx_ready); end
      tx_data = 8'(j + 1);
      m_acc.push_back(j);
      m_byte.push_back(8'(j + 1));
    end
    tick();
    n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL full_count got=%0d exp=4", fifo_count); end
    n_checks++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got=%b exp=0", tx_ready); end
    tx_data = 8'hEE;
    tick();
    n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL full_refused_count got=%0d exp=4", fifo_count); end
    tx_valid = 1'b0;
    while (now < 5 * FCLK + 3) tick();
    #1;
    rec_on = 1'b0;
    for (int t = 0; t < rec_n; t++) begin
      n_checks++;
      if (cap_tx[t] !== exp_line(t)) begin
        n_fail++;
        $display("FAIL full_line t=%0d got=%b exp=%b", t, cap_tx[t], exp_line(t));
      end
      n_checks++;
      if (cap_done[t] !== exp_done(t)) begin
        n_fail++;
        $display("FAIL full_done t=%0d got=%b exp=%b", t, cap_done[t], exp_done(t));
      end
    end
  endtask

  task automatic test_full_pop();
    logic [7:0] b;
    do_reset();
    b = 8'($urandom);
    first_push(b);
    for (int j = 1; j < 5; j++) begin
      tick();
      b = 8'($urandom);
      tx_data = b;
      m_acc.push_back(j);
      m_byte.push_back(b);
    end
    tick();
    tx_valid = 1'b0;
    while (now < FCLK) tick();
    n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL pop_count_before got=%0d exp=4", fifo_count); end
    b = 8'($urandom);
    tx_data = b;
    tx_valid = 1'b1;
    tick();
    n_checks++; if (fifo_count !== 3'd3) begin n_fail++; $display("FAIL pop_count_after_pop got=%0d exp=3", fifo_count); end
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL pop_ready got=%b exp=1", tx_ready); end
    m_acc.push_back(now + 1);
    m_byte.push_back(b);
    tick();
    n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL pop_count_refill got=%0d exp=4", fifo_count); end
    tx_valid = 1'b0;
    while (now < 6 * FCLK + 3) tick();
    #1;
    rec_on = 1'b0;
    for (int t = 0; t < rec_n; t++) begin
      n_checks++;
      if (cap_tx[t] !== exp_line(t)) begin
        n_fail++;
        $display("FAIL pop_line t=%0d got=%b exp=%b", t, cap_tx[t], exp_line(t));
      end
      n_checks++;
      if (cap_done[t] !== exp_done(t)) begin
        n_fail++;
        $display("FAIL pop_done t=%0d got=%b exp=%b", t, cap_done[t], exp_done(t));
      end
    end
  endtask

  task automatic test_back_to_back();
    int         push_at [4];
    logic [7:0] bytes   [4];
    int         next_k;
    int         end_t;
    do_reset();
    push_at[0] = -1;
    for (int k = 0; k < 4; k++) bytes[k] = 8'($urandom);
    for (int k = 1; k < 4; k++) push_at[k] = push_at[k-1] + 1 + int'($urandom_range(0, 60));
    first_push(bytes[0]);
    for (int k = 1; k < 4; k++) begin
      m_acc.push_back(push_at[k] + 1);
      m_byte.push_back(bytes[k]);
    end
    end_t = m_start(3) + FCLK + 2;
    next_k = 1;
    while (now < end_t) begin
      tick();
      if (next_k < 4 && now == push_at[next_k]) begin
        tx_data = bytes[next_k];
        tx_valid = 1'b1;
        next_k++;
      end else begin
        tx_valid = 1'b0;
      end
    end
    #1;
    rec_on = 1'b0;
    for (int t = 0; t < rec_n; t++) begin
      n_checks++;
      if (cap_tx[t] !== exp_line(t)) begin
        n_fail++;
        $display("FAIL b2b_line t=%0d got=%b exp=%b", t, cap_tx[t], exp_line(t));
      end
      n_checks++;
      if (cap_done[t] !== exp_done(t)) begin
        n_fail++;
        $display("FAIL b2b_done t=%0d got=%b exp=%b", t, cap_done[t], exp_done(t));
      end
      n_checks++;
      if (cap_busy[t] !== exp_busy(t)) begin
        n_fail++;
        $display("FAIL b2b_busy t=%0d got=%b exp=%b", t, cap_busy[t], exp_busy(t));
      end
    end
  endtask

  task automatic test_reset_midframe();
    int rst_t;
    do_reset();
    first_push(8'hFF);
    tick();
    tx_data = 8'h3C;
    m_acc.push_back(1);
    m_byte.push_back(8'h3C);
    tick();
    tx_data = 8'hC3;
    m_acc.push_back(2);
    m_byte.push_back(8'hC3);
    tick();
    tx_valid = 1'b0;
    // Data bit 3 occupies samples 17..20.
    while (now < 18) tick();
    n_checks++; if (fifo_count !== 3'd2) begin n_fail++; $display("FAIL mid_count_before got=%0d exp=2", fifo_count); end
    rst_t = now;
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL mid_rst_uart_tx got=%b exp=1", uart_tx); end
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL mid_rst_count got=%0d exp=0", fifo_count); end
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy got=%b exp=0", tx_busy); end
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready got=%b exp=1", tx_ready); end
    n_checks++; if (tx_done !== 1'b0) begin n_fail++; $display("FAIL mid_rst_done got=%b exp=0", tx_done); end
    repeat (3) tick();
    rst = 1'b0;
    repeat (100) tick();
    #1;
    rec_on = 1'b0;
    for (int t = 0; t < rec_n; t++) begin
      if (t <= rst_t) begin
        n_checks++;
        if (cap_tx[t] !== exp_line(t)) begin
          n_fail++;
          $display("FAIL mid_pre_line t=%0d got=%b exp=%b", t, cap_tx[t], exp_line(t));
        end
      end else begin
        n_checks++;
        if (cap_tx[t] !== 1'b1 || cap_done[t] !== 1'b0 || cap_cnt[t] !== 3'd0) begin
          n_fail++;
          $display("FAIL mid_post t=%0d got tx/done/count=%b/%b/%0d exp=1/0/0", t, cap_tx[t], cap_done[t], cap_cnt[t]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frames();
    test_fifo_full();
    test_full_pop();
    test_back_to_back();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
